fifo_flagged: RTL and testbench
===============================

# fifo_flagged

Parametrised synchronous FIFO, the successor to the team's basic single-clock FIFO. It adds occupancy count, programmable almost-full/almost-empty thresholds, and sticky overflow/underflow error flags. A first-word-fall-through (FWFT) mode is selectable. It sits between producer and consumer blocks in one clock domain and is the default buffering element for new datapaths.

## Interface
- DATA_WIDTH, 8, width of each stored word
- DEPTH, 16, number of entries; must be a power of two and at least 2; ADDR_WIDTH = $clog2(DEPTH)
- AF_THRESH, DEPTH-2, almost_full asserts when count >= AF_THRESH; legal range 1..DEPTH
- AE_THRESH, 2, almost_empty asserts when count <= AE_THRESH; legal range 0..DEPTH-1
- FWFT, 0, 0 = standard registered read, 1 = first-word-fall-through
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- wr_en  in  1  write request
- wr_data  in  DATA_WIDTH  write data, sampled with wr_en
- rd_en  in  1  read request (pop)
- clr_err  in  1  clears overflow/underflow
- rd_data  out  DATA_WIDTH  read data
- full  out  1  count == DEPTH
- empty  out  1  count == 0
- almost_full  out  1  count >= AF_THRESH
- almost_empty  out  1  count <= AE_THRESH
- count  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
- overflow  out  1  sticky: a write was rejected
- underflow  out  1  sticky: a read was rejected

## Operation
- Reset (rst_n low, asynchronous) sets the following:
  - Pointers and count go to 0.
  - rd_data = 0, overflow = 0, underflow = 0.
  - empty = 1, almost_empty = 1, full = 0, almost_full = 0.
  - Memory contents are not reset.
- Read accepted (rd_acc) = rd_en && !empty.
- Write accepted (wr_acc) = wr_en && (!full || rd_acc). A write to a full FIFO succeeds only if a read is accepted in the same cycle.
- A read from an empty FIFO is always rejected, even when a write is accepted in the same cycle.
- Pointers are ADDR_WIDTH bits and wrap naturally from DEPTH-1 to 0. Full and empty are derived from count, not from pointer comparison.
- Count update per edge:
  - +1 on wr_acc only.
  - -1 on rd_acc only.
  - Unchanged when both are accepted or neither is.
- All flags are combinational decodes of the registered count, so they change only after the accepting edge.
- Standard mode (FWFT=0):
  - On rd_acc, rd_data <= mem[rd_ptr].
  - Otherwise rd_data holds its last value.
- FWFT mode (FWFT=1):
  - rd_data = mem[rd_ptr] while !empty, and 0 while empty.
  - rd_en acknowledges the shown word and advances to the next one.
- overflow sets on wr_en && !wr_acc. underflow sets on rd_en && !rd_acc.
  - Both clear on clr_err.
  - If clr_err and a new error occur in the same cycle, the flag sets (the error wins).
  - Rejected operations change no other state.

## Timing
- Write latency:
  - wr_acc at edge N makes the word readable from cycle N+1.
  - empty deasserts after edge N.
- Standard read latency is 1:
  - rd_en high at edge N gives rd_data valid after edge N.
  - The value is held until the next accepted read.
- FWFT read latency is 0:
  - The head word is on rd_data in the same cycle empty is low.
  - After rd_acc at edge N, the next word (or 0) appears after edge N.
- count, full, empty, almost_* update after the same edge that accepts the operation.
- overflow and underflow assert after the edge where the rejected request is sampled.
- Reset asserted mid-operation takes effect immediately (asynchronous). The FIFO reads as empty afterwards, with no residual words visible after rst_n deasserts.

## Test plan
- Basic order, FWFT=0:
  - Stimulus: write 11, 22, 33, 44 on consecutive edges, idle 2 cycles, then read 4 consecutive cycles.
  - Required: rd_data = 11, 22, 33, 44 one cycle after each rd_en; count goes 0→4→0; empty high at the end.
- Fill and overflow:
  - Stimulus: write 16 words 1..16, then one more write of 99.
  - Required: full = 1 and count = 16 after the 16th write; almost_full first asserts at count = 14; overflow = 1 after the 17th; 99 is not stored; draining returns 1..16.
- Underflow and clear:
  - Stimulus: rd_en on the empty FIFO.
  - Required: underflow = 1; rd_data unchanged; count = 0.
  - Stimulus: clr_err for 1 cycle.
  - Required: underflow = 0.
  - Stimulus: clr_err together with another empty read.
  - Required: underflow stays 1.
- Simultaneous read/write at boundaries:
  - Stimulus: at full, wr_en + rd_en.
  - Required: both accepted, count stays 16, no overflow.
  - Stimulus: at empty, wr_en + rd_en.
  - Required: write accepted, read rejected, count = 1, underflow = 1.
- Wrap-around:
  - Stimulus: write 16 words, read 8, write 8 words 101..108, then read 16.
  - Required: output is 9..16 followed by 101..108.
- FWFT=1 and reset mid-operation:
  - Stimulus: write 5.
  - Required: rd_data = 5 in the cycle after the write edge, before any rd_en.
  - Stimulus: write 6, 7, then assert rst_n low mid-cycle.
  - Required: count = 0, empty = 1, rd_data = 0 immediately.

Source files
------------

// File: rtl/fifo_flagged.sv
`default_nettype none
// ============================================================================
//  Module      : fifo_flagged
//  Description : Single-clock synchronous FIFO with occupancy count,
//                programmable almost-full / almost-empty thresholds, sticky
//                overflow / underflow error flags and an optional
//                first-word-fall-through (FWFT) read port.
//  Revision    : 1.0 - initial release
// ============================================================================
module fifo_flagged #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16,
  parameter int AF_THRESH  = DEPTH - 2,
  parameter int AE_THRESH  = 2,
  parameter int FWFT       = 0,
  localparam int ADDR_WIDTH = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  input  logic                  clr_err,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  overflow,
  output logic                  underflow
);

  // --------------------------------------------------------------------------
  // Constants sized to the count / pointer width so every compare and
  // increment below is width-exact.
  // --------------------------------------------------------------------------
  localparam logic [ADDR_WIDTH:0]   c_depth    = DEPTH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   c_af_thr   = AF_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   c_ae_thr   = AE_THRESH[ADDR_WIDTH:0];
  localparam logic [ADDR_WIDTH:0]   c_cnt_one  = {{ADDR_WIDTH{1'b0}}, 1'b1};
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one  = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  // --------------------------------------------------------------------------
  // Storage and state
  // --------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  // --------------------------------------------------------------------------
  // Flag decode and handshake qualification
  // --------------------------------------------------------------------------
  logic w_full;
  logic w_empty;
  logic w_rd_acc;
  logic w_wr_acc;
  logic w_wr_rej;
  logic w_rd_rej;

  // Flags come straight from the registered count so they move only after
  // the edge that accepted the operation; pointers never decide full/empty.
  assign w_full  = (r_count == c_depth);
  assign w_empty = (r_count == '0);

  // A read of an empty FIFO is always refused, even if a write lands in the
  // same cycle. A write into a full FIFO is allowed only when a read frees
  // the slot on the same edge.
  assign w_rd_acc = rd_en && !w_empty;
  assign w_wr_acc = wr_en && (!w_full || w_rd_acc);
  assign w_wr_rej = wr_en && !w_wr_acc;
  assign w_rd_rej = rd_en && !w_rd_acc;

  // Memory write port; contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  // Write pointer advances on every accepted write, wrapping at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
    end else if (w_wr_acc) begin
      r_wr_ptr <= r_wr_ptr + c_ptr_one;
    end
  end

  // Read pointer advances on every accepted read, wrapping at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
    end else if (w_rd_acc) begin
      r_rd_ptr <= r_rd_ptr + c_ptr_one;
    end
  end

  // Occupancy: net effect of the accepted write and read on this edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else begin
      case ({w_wr_acc, w_rd_acc})
        2'b10:   r_count <= r_count + c_cnt_one;
        2'b01:   r_count <= r_count - c_cnt_one;
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky error flags; a fresh error on the clearing cycle takes priority.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_wr_rej) begin
        r_overflow <= 1'b1;
      end else if (clr_err) begin
        r_overflow <= 1'b0;
      end

      if (w_rd_rej) begin
        r_underflow <= 1'b1;
      end else if (clr_err) begin
        r_underflow <= 1'b0;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Read data path
  // --------------------------------------------------------------------------
  generate
    if (FWFT != 0) begin : g_fwft
      // The head word is always presented; rd_en only acknowledges it.
      // Forcing zero while empty hides stale memory after reset or drain.
      assign rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    end else begin : g_std
      logic [DATA_WIDTH-1:0] r_rd_data;

      // Registered read: capture the head word on an accepted read and hold
      // it until the next one.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_rd_data <= '0;
        end else if (w_rd_acc) begin
          r_rd_data <= r_mem[r_rd_ptr];
        end
      end

      assign rd_data = r_rd_data;
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Status outputs
  // --------------------------------------------------------------------------
  assign full         = w_full;
  assign empty        = w_empty;
  assign almost_full  = (r_count >= c_af_thr);
  assign almost_empty = (r_count <= c_ae_thr);
  assign count        = r_count;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_fifo_flagged.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fifo_flagged
//  Description : Directed self-checking bench for fifo_flagged; one
//                registered-read instance and one FWFT instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fifo_flagged;

  logic       clk;
  // registered-read instance
  logic       rst_n, wr_en, rd_en, clr_err;
  logic [7:0] wr_data, rd_data;
  logic       full, empty, almost_full, almost_empty, overflow, underflow;
  logic [4:0] count;
  // FWFT instance
  logic       f_rst_n, f_wr_en, f_rd_en, f_clr_err;
  logic [7:0] f_wr_data, f_rd_data;
  logic       f_full, f_empty, f_almost_full, f_almost_empty, f_overflow, f_underflow;
  logic [4:0] f_count;

  int n_assert = 0;
  int n_fail   = 0;

  fifo_flagged #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(0)) u_std (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .clr_err(clr_err), .rd_data(rd_data), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  fifo_flagged #(.DATA_WIDTH(8), .DEPTH(16), .AF_THRESH(14), .AE_THRESH(2), .FWFT(1)) u_fw (
    .clk(clk), .rst_n(f_rst_n), .wr_en(f_wr_en), .wr_data(f_wr_data), .rd_en(f_rd_en),
    .clr_err(f_clr_err), .rd_data(f_rd_data), .full(f_full), .empty(f_empty),
    .almost_full(f_almost_full), .almost_empty(f_almost_empty), .count(f_count),
    .overflow(f_overflow), .underflow(f_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 time unit past it before sampling/driving.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    rst_n = 1'b0; wr_en = 1'b0; rd_en = 1'b0; clr_err = 1'b0; wr_data = 8'd0;
    f_rst_n = 1'b0; f_wr_en = 1'b0; f_rd_en = 1'b0; f_clr_err = 1'b0; f_wr_data = 8'd0;
    step(); step();

    // ---------------- reset state ----------------
    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_aempty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_afull", 32'(almost_full), 0);
    chk("rst_rd_data", 32'(rd_data), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_unf", 32'(underflow), 0);
    rst_n = 1'b1;
    step();

    // ---------------- basic order ----------------
    wr_en = 1'b1; wr_data = 8'd11; step();
    chk("b_empty_after_wr1", 32'(empty), 0);
    chk("b_count1", 32'(count), 1);
    wr_data = 8'd22; step();
    wr_data = 8'd33; step();
    wr_data = 8'd44; step();
    wr_en = 1'b0;
    chk("b_count4", 32'(count), 4);
    step(); step();
    rd_en = 1'b1; step(); chk("b_rd0", 32'(rd_data), 11);
    step(); chk("b_rd1", 32'(rd_data), 22);
    step(); chk("b_rd2", 32'(rd_data), 33);
    step(); chk("b_rd3", 32'(rd_data), 44);
    rd_en = 1'b0;
    chk("b_count0", 32'(count), 0);
    chk("b_empty_end", 32'(empty), 1);
    step();
    chk("b_hold", 32'(rd_data), 44);

    // ---------------- fill and overflow ----------------
    wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i);
      step();
      chk("f_count", 32'(count), 32'(i));
      chk("f_afull", 32'(almost_full), 32'(i >= 14));
      chk("f_aempty", 32'(almost_empty), 32'(i <= 2));
    end
    chk("f_full", 32'(full), 1);
    wr_data = 8'd99; step();
    wr_en = 1'b0;
    chk("f_ovf", 32'(overflow), 1);
    chk("f_count_ovf", 32'(count), 16);
    rd_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      step();
      chk("f_drain", 32'(rd_data), 32'(i));
    end
    rd_en = 1'b0;
    chk("f_empty", 32'(empty), 1);
    chk("f_ovf_sticky", 32'(overflow), 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("f_ovf_clr", 32'(overflow), 0);

    // ---------------- underflow and clear ----------------
    rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("u_unf", 32'(underflow), 1);
    chk("u_rd_hold", 32'(rd_data), 16);
    chk("u_count", 32'(count), 0);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("u_clr", 32'(underflow), 0);
    clr_err = 1'b1; rd_en = 1'b1; step(); clr_err = 1'b0; rd_en = 1'b0;
    chk("u_err_wins", 32'(underflow), 1);
    clr_err = 1'b1; step(); clr_err = 1'b0;
    chk("u_clr2", 32'(underflow), 0);

    // ---------------- simultaneous read/write at boundaries ----------------
    wr_en = 1'b1;
    for (int i = 0; i < 16; i++) begin
      wr_data = 8'(200 + i);
      step();
    end
    chk("s_full", 32'(full), 1);
    wr_data = 8'd77; rd_en = 1'b1; step();
    wr_en = 1'b0;
    chk("s_full_rd", 32'(rd_data), 200);
    chk("s_full_count", 32'(count), 16);
    chk("s_full_noovf", 32'(overflow), 0);
    for (int i = 1; i < 16; i++) begin
      step();
      chk("s_drain", 32'(rd_data), 32'(200 + i));
    end
    step();
    chk("s_drain_last", 32'(rd_data), 77);
    chk("s_empty", 32'(empty), 1);
    wr_en = 1'b1; wr_data = 8'd55; step();
    wr_en = 1'b0; rd_en = 1'b0;
    chk("s_empty_count", 32'(count), 1);
    chk("s_empty_unf", 32'(underflow), 1);
    chk("s_empty_rd_hold", 32'(rd_data), 77);
    chk("s_empty_noovf", 32'(overflow), 0);
    clr_err = 1'b1; rd_en = 1'b1; step(); clr_err = 1'b0; rd_en = 1'b0;
    chk("s_rd55", 32'(rd_data), 55);
    chk("s_unf_clr", 32'(underflow), 0);
    chk("s_count0", 32'(count), 0);

    // ---------------- wrap-around ----------------
    wr_en = 1'b1;
    for (int i = 1; i <= 16; i++) begin
      wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0; rd_en = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step();
      chk("w_rd_first", 32'(rd_data), 32'(i));
    end
    rd_en = 1'b0; wr_en = 1'b1;
    for (int i = 101; i <= 108; i++) begin
      wr_data = 8'(i);
      step();
    end
    wr_en = 1'b0;
    chk("w_full", 32'(full), 1);
    rd_en = 1'b1;
    for (int i = 9; i <= 16; i++) begin
      step();
      chk("w_rd_old", 32'(rd_data), 32'(i));
    end
    for (int i = 101; i <= 108; i++) begin
      step();
      chk("w_rd_new", 32'(rd_data), 32'(i));
    end
    rd_en = 1'b0;
    chk("w_empty", 32'(empty), 1);

    // ---------------- asynchronous reset mid-operation (registered) ----------------
    wr_en = 1'b1; wr_data = 8'd3; step();
    wr_data = 8'd4; step();
    wr_en = 1'b0; rd_en = 1'b1; step(); rd_en = 1'b0;
    chk("r_pre_rd", 32'(rd_data), 3);
    #2 rst_n = 1'b0;
    #1;
    chk("r_async_count", 32'(count), 0);
    chk("r_async_empty", 32'(empty), 1);
    chk("r_async_rd", 32'(rd_data), 0);
    step();
    rst_n = 1'b1;
    step();
    chk("r_post_empty", 32'(empty), 1);

    // ---------------- FWFT ----------------
    chk("fw_rst_rd", 32'(f_rd_data), 0);
    chk("fw_rst_empty", 32'(f_empty), 1);
    f_rst_n = 1'b1; step();
    f_wr_en = 1'b1; f_wr_data = 8'd5; step();
    f_wr_en = 1'b0;
    chk("fw_show5", 32'(f_rd_data), 5);
    chk("fw_count1", 32'(f_count), 1);
    f_wr_en = 1'b1; f_wr_data = 8'd6; step();
    f_wr_data = 8'd7; step();
    f_wr_en = 1'b0;
    chk("fw_still5", 32'(f_rd_data), 5);
    chk("fw_count3", 32'(f_count), 3);
    f_rd_en = 1'b1; step(); f_rd_en = 1'b0;
    chk("fw_show6", 32'(f_rd_data), 6);
    chk("fw_count2", 32'(f_count), 2);
    #2 f_rst_n = 1'b0;
    #1;
    chk("fw_async_count", 32'(f_count), 0);
    chk("fw_async_empty", 32'(f_empty), 1);
    chk("fw_async_rd", 32'(f_rd_data), 0);
    step();
    f_rst_n = 1'b1;
    step();
    chk("fw_post_rd", 32'(f_rd_data), 0);
    chk("fw_post_empty", 32'(f_empty), 1);
    f_rd_en = 1'b1; step(); f_rd_en = 1'b0;
    chk("fw_post_unf", 32'(f_underflow), 1);
    chk("fw_post_count", 32'(f_count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
